// File: rtl/fd_pulse_qualifier_stamper_if.sv
// Timestamp stream interface between the pulse qualifier/stamper and the channel delay logic.
//   ts_data_o  : head-of-FIFO timestamp (producer -> consumer)
//   ts_valid_o : FIFO not empty (producer -> consumer)
//   ts_ready_i : consumer pop request (consumer -> producer)
interface fd_pulse_qualifier_stamper_if #(
  parameter int unsigned g_cnt_width = 16
);
  logic [g_cnt_width-1:0] ts_data_o;
  logic                   ts_valid_o;
  logic                   ts_ready_i;

  modport master (
    output ts_data_o,
    output ts_valid_o,
    input  ts_ready_i
  );

  modport slave (
    input  ts_data_o,
    input  ts_valid_o,
    output ts_ready_i
  );
endinterface

// File: rtl/fd_pulse_qualifier_stamper.sv
// Trigger pulse qualifier and time-stamper for a delay channel.
// Synchronises an asynchronous trigger, rejects pulses shorter than g_min_width cycles, applies a
// dead time after each qualified pulse and stamps each qualified pulse with the coarse counter
// value at the synchronised rising edge. Stamps are queued in a first-word-fall-through FIFO.
// Ports:
//   clk_ref_i      : reference clock (single domain)
//   rst_ref_i      : synchronous active-high reset
//   enable_i       : qualifier enable; low forces the FSM idle and discards any capture
//   pulse_a_i      : asynchronous trigger input
//   ts_if          : timestamp stream (data / valid / ready), master side
//   overflow_o     : sticky, set when a qualified stamp is dropped on a full FIFO
//   clr_overflow_i : clears overflow_o (a simultaneous drop wins)
//   glitch_cnt_o   : saturating count of rejected short pulses
//   cnt_o          : free-running coarse counter
module fd_pulse_qualifier_stamper #(
  parameter int unsigned g_sync_stages = 2,
  parameter int unsigned g_min_width   = 3,
  parameter int unsigned g_dead_time   = 16,
  parameter int unsigned g_cnt_width   = 16,
  parameter int unsigned g_fifo_depth  = 4
) (
  input  logic                         clk_ref_i,
  input  logic                         rst_ref_i,
  input  logic                         enable_i,
  input  logic                         pulse_a_i,
  fd_pulse_qualifier_stamper_if.master ts_if,
  output logic                         overflow_o,
  input  logic                         clr_overflow_i,
  output logic [15:0]                  glitch_cnt_o,
  output logic [g_cnt_width-1:0]       cnt_o
);

  localparam int unsigned WcntW = (g_min_width > 1) ? $clog2(g_min_width) : 1;
  localparam int unsigned DcntW = (g_dead_time > 1) ? $clog2(g_dead_time) : 1;
  localparam int unsigned PtrW  = $clog2(g_fifo_depth);
  localparam int unsigned OccW  = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StWidth, StDead} state_e;

  // Synchroniser and edge detect
  logic [g_sync_stages-1:0] r_sync;
  logic                     r_s_d;
  logic                     w_s;
  logic                     w_rise;

  assign w_s    = r_sync[g_sync_stages-1];
  assign w_rise = w_s & ~r_s_d;

  // Qualifier state
  state_e                 r_state, w_state_d;
  logic [WcntW-1:0]       r_wcnt, w_wcnt_d;
  logic [DcntW-1:0]       r_dcnt, w_dcnt_d;
  logic [g_cnt_width-1:0] r_ts_cap, w_ts_cap_d;
  logic [g_cnt_width-1:0] r_cnt;
  logic [15:0]            r_glitch_cnt;
  logic                   w_push;
  logic [g_cnt_width-1:0] w_push_data;
  logic                   w_glitch;

  // FIFO state
  logic [g_cnt_width-1:0] r_mem [g_fifo_depth];
  logic [PtrW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [OccW-1:0]        r_count;
  logic [g_cnt_width-1:0] r_hold;
  logic                   r_overflow;
  logic                   w_valid, w_full, w_pop, w_push_ok, w_drop;

  always_ff @(posedge clk_ref_i) begin
    if (rst_ref_i) begin
      r_sync   <= '0;
      r_s_d    <= 1'b0;
      r_cnt    <= '0;
      r_state  <= StIdle;
      r_wcnt   <= '0;
      r_dcnt   <= '0;
      r_ts_cap <= '0;
    end else begin
      r_sync   <= {r_sync[g_sync_stages-2:0], pulse_a_i};
      r_s_d    <= w_s;
      r_cnt    <= r_cnt + g_cnt_width'(1);
      r_state  <= w_state_d;
      r_wcnt   <= w_wcnt_d;
      r_dcnt   <= w_dcnt_d;
      r_ts_cap <= w_ts_cap_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_wcnt_d    = r_wcnt;
    w_dcnt_d    = r_dcnt;
    w_ts_cap_d  = r_ts_cap;
    w_push      = 1'b0;
    w_push_data = r_ts_cap;
    w_glitch    = 1'b0;
    if (!enable_i) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_rise) begin
            w_ts_cap_d = r_cnt;
            if (g_min_width == 1) begin
              // A single high cycle already qualifies: stamp straight from the counter.
              w_push      = 1'b1;
              w_push_data = r_cnt;
              w_dcnt_d    = '0;
              w_state_d   = StDead;
            end else begin
              w_wcnt_d  = WcntW'(1);
              w_state_d = StWidth;
            end
          end
        end
        StWidth: begin
          if (!w_s) begin
            w_glitch  = 1'b1;
            w_state_d = StIdle;
          end else if (r_wcnt == WcntW'(g_min_width - 1)) begin
            // This cycle is the g_min_width-th high cycle.
            w_push    = 1'b1;
            w_dcnt_d  = '0;
            w_state_d = StDead;
          end else begin
            w_wcnt_d = r_wcnt + WcntW'(1);
          end
        end
        StDead: begin
          // Counter saturates at the end of the dead time; a held-high input keeps us here.
          if (r_dcnt == DcntW'(g_dead_time - 1)) begin
            if (!w_s) w_state_d = StIdle;
          end else begin
            w_dcnt_d = r_dcnt + DcntW'(1);
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_ref_i) begin
    if (rst_ref_i) begin
      r_glitch_cnt <= '0;
    end else if (w_glitch && (r_glitch_cnt != 16'hFFFF)) begin
      r_glitch_cnt <= r_glitch_cnt + 16'd1;
    end
  end

  // FIFO control
  assign w_valid   = (r_count != '0);
  assign w_full    = (r_count == OccW'(g_fifo_depth));
  assign w_pop     = w_valid & ts_if.ts_ready_i;
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & ~w_push_ok;

  always_ff @(posedge clk_ref_i) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk_ref_i) begin
    if (rst_ref_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_hold     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
        // Keep the popped word so ts_data_o holds its last value once empty.
        r_hold   <= r_mem[r_rd_ptr];
      end
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + OccW'(1);
      end else if (!w_push_ok && w_pop) begin
        r_count <= r_count - OccW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow_i) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign ts_if.ts_data_o  = w_valid ? r_mem[r_rd_ptr] : r_hold;
  assign ts_if.ts_valid_o = w_valid;
  assign overflow_o       = r_overflow;
  assign glitch_cnt_o     = r_glitch_cnt;
  assign cnt_o            = r_cnt;

endmodule

// File: tb/tb_fd_pulse_qualifier_stamper.sv
// Self-checking bench for fd_pulse_qualifier_stamper: directed scenarios plus a randomized phase,
// every cycle compared against a time-based behavioural model of the qualifier and stamp queue.
module tb_fd_pulse_qualifier_stamper;

  localparam int unsigned SYNC  = 2;
  localparam int unsigned MINW  = 3;
  localparam int unsigned DEAD  = 16;
  localparam int unsigned CW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MASK  = (1 << CW) - 1;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          en    = 1'b1;
  logic          pulse = 1'b0;
  logic          rdy   = 1'b0;
  logic          clr   = 1'b0;
  logic          ovf;
  logic [15:0]   gcnt;
  logic [CW-1:0] cnt;

  always #5 clk = ~clk;

  fd_pulse_qualifier_stamper_if #(.g_cnt_width(CW)) ts_if ();
  assign ts_if.ts_ready_i = rdy;

  fd_pulse_qualifier_stamper #(
    .g_sync_stages(SYNC),
    .g_min_width  (MINW),
    .g_dead_time  (DEAD),
    .g_cnt_width  (CW),
    .g_fifo_depth (DEPTH)
  ) dut (
    .clk_ref_i     (clk),
    .rst_ref_i     (rst),
    .enable_i      (en),
    .pulse_a_i     (pulse),
    .ts_if         (ts_if),
    .overflow_o    (ovf),
    .clr_overflow_i(clr),
    .glitch_cnt_o  (gcnt),
    .cnt_o         (cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: time-based view of the qualifier plus a queue of stamps
  bit          m_pipe[SYNC];
  bit          m_sd;
  int unsigned m_cnt;
  int          m_cyc;
  bit          m_cand;
  int          m_cand_cyc;
  int unsigned m_cand_stamp;
  bit          m_dead;
  int          m_qual_cyc;
  int unsigned m_q[$];
  int unsigned m_hold;
  bit          m_ovf;
  int unsigned m_glitch;

  function automatic void model_reset();
    for (int i = 0; i < int'(SYNC); i++) m_pipe[i] = 1'b0;
    m_sd = 0; m_cnt = 0; m_cyc = 0; m_cand = 0; m_dead = 0;
    m_q.delete(); m_hold = 0; m_ovf = 0; m_glitch = 0;
  endfunction

  // One clock edge, using the inputs currently driven.
  function automatic void model_step();
    bit          s, rise, push, pop, drop;
    int unsigned pv, sz;
    if (rst) begin
      model_reset();
      return;
    end
    s    = m_pipe[SYNC-1];
    rise = s && !m_sd;
    push = 0;
    pv   = 0;
    if (!en) begin
      m_cand = 0;
      m_dead = 0;
    end else if (m_dead) begin
      if ((m_cyc - m_qual_cyc) >= int'(DEAD) && !s) m_dead = 0;
    end else if (m_cand) begin
      if (!s) begin
        m_cand = 0;
        if (m_glitch < 16'hFFFF) m_glitch++;
      end else if (m_cyc - m_cand_cyc + 1 == int'(MINW)) begin
        push = 1; pv = m_cand_stamp; m_cand = 0; m_dead = 1; m_qual_cyc = m_cyc;
      end
    end else if (rise) begin
      if (MINW == 1) begin
        push = 1; pv = m_cnt; m_dead = 1; m_qual_cyc = m_cyc;
      end else begin
        m_cand = 1; m_cand_cyc = m_cyc; m_cand_stamp = m_cnt;
      end
    end
    sz   = m_q.size();
    pop  = (sz > 0) && rdy;
    drop = push && !(sz < DEPTH || pop);
    if (pop) m_hold = m_q.pop_front();
    if (push && !drop) m_q.push_back(pv);
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    m_cnt = (m_cnt + 1) & MASK;
    m_sd  = s;
    for (int i = int'(SYNC) - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = pulse;
    m_cyc++;
  endfunction

  function automatic bit model_will_push();
    return en && m_cand && !m_dead && m_pipe[SYNC-1] && (m_cyc - m_cand_cyc + 1 == int'(MINW));
  endfunction

  task automatic compare_all();
    bit          ev;
    int unsigned ed;
    ev = (m_q.size() > 0);
    ed = ev ? m_q[0] : m_hold;
    check("valid", 32'(ts_if.ts_valid_o), 32'(ev));
    check("data", 32'(ts_if.ts_data_o), ed);
    check("overflow", 32'(ovf), 32'(m_ovf));
    check("glitch_cnt", 32'(gcnt), m_glitch);
    check("cnt", 32'(cnt), m_cnt);
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse_gen(input int hi, input int lo);
    pulse = 1'b1;
    repeat (hi) step();
    pulse = 1'b0;
    repeat (lo) step();
  endtask

  logic [CW-1:0] popped[$];

  task automatic drain();
    popped.delete();
    rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (ts_if.ts_valid_o !== 1'b1) break;
      popped.push_back(ts_if.ts_data_o);
      step();
    end
    rdy = 1'b0;
  endtask

  initial begin
    int          lat;
    int unsigned c0;
    bit          found;
    int          hold_left;

    model_reset();
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    check("rst_valid", 32'(ts_if.ts_valid_o), 32'd0);
    check("rst_data", 32'(ts_if.ts_data_o), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    repeat (5) step();

    // 1: single 10-cycle pulse, stamp and latency
    c0    = m_cnt;
    pulse = 1'b1;
    lat   = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      lat++;
      if (ts_if.ts_valid_o === 1'b1) break;
    end
    check("t1_latency", 32'(lat), 32'(SYNC + MINW));
    repeat (10 - lat) step();
    pulse = 1'b0;
    repeat (30) step();
    drain();
    check("t1_entries", 32'(popped.size()), 32'd1);
    if (popped.size() > 0) check("t1_stamp", 32'(popped[0]), (c0 + SYNC) & MASK);

    // 2: short pulse rejected as glitch
    pulse_gen(2, 30);
    check("t2_glitch", 32'(gcnt), 32'd1);
    drain();
    check("t2_entries", 32'(popped.size()), 32'd0);

    // 3: second pulse inside dead time ignored; spaced pulses both stamped
    pulse_gen(5, 3);
    pulse_gen(5, 40);
    drain();
    check("t3_dead_entries", 32'(popped.size()), 32'd1);
    pulse_gen(5, 33);
    pulse_gen(5, 40);
    drain();
    check("t3_sep_entries", 32'(popped.size()), 32'd2);
    if (popped.size() == 2) check("t3_delta", 32'(CW'(popped[1] - popped[0])), 32'd38);

    // 4: overflow with a stalled consumer
    rdy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      pulse_gen(5, 35);
      if (k == 3) check("t4_ovf_at4", 32'(ovf), 32'd0);
      if (k == 4) check("t4_ovf_at5", 32'(ovf), 32'd1);
    end
    drain();
    check("t4_entries", 32'(popped.size()), 32'd4);
    for (int k = 0; k + 1 < popped.size(); k++)
      check("t4_order", 32'(CW'(popped[k+1] - popped[k])), 32'd40);
    check("t4_ovf_sticky", 32'(ovf), 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t4_ovf_clr", 32'(ovf), 32'd0);
    for (int k = 0; k < 4; k++) pulse_gen(5, 35);
    pulse = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (model_will_push()) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("t4_push_seen", 32'(found), 32'd1);
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    repeat (2) step();
    pulse = 1'b0;
    repeat (35) step();
    check("t4_ovf_poppush", 32'(ovf), 32'd0);
    drain();
    check("t4_full_entries", 32'(popped.size()), 32'd4);

    // 5: held-high input across counter wrap
    for (int i = 0; i < 70000 && m_cnt != MASK; i++) step();
    c0 = m_cnt;
    pulse_gen(100, 40);
    drain();
    check("t5_entries", 32'(popped.size()), 32'd1);
    if (popped.size() > 0) check("t5_wrap_stamp", 32'(popped[0]), (c0 + SYNC) & MASK);

    // 6: enable drop during width check, then reset with entries queued
    pulse = 1'b1;
    repeat (SYNC + 1) step();
    en = 1'b0;
    step();
    en = 1'b1;
    repeat (5) step();
    pulse = 1'b0;
    repeat (30) step();
    check("t6_no_glitch", 32'(gcnt), 32'd1);
    drain();
    check("t6_entries", 32'(popped.size()), 32'd0);
    pulse_gen(5, 35);
    pulse_gen(5, 35);
    check("t6_queued", 32'(ts_if.ts_valid_o), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_valid", 32'(ts_if.ts_valid_o), 32'd0);
    check("t6_rst_ovf", 32'(ovf), 32'd0);
    check("t6_rst_cnt", 32'(cnt), 32'd0);
    repeat (5) step();

    // Randomized phase
    hold_left = 0;
    for (int i = 0; i < 2500; i++) begin
      if (hold_left == 0) begin
        pulse     = ~pulse;
        hold_left = pulse ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 30));
      end
      hold_left--;
      en  = ($urandom_range(0, 49) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 999) == 0);
      step();
    end
    rst   = 1'b0;
    en    = 1'b1;
    rdy   = 1'b0;
    clr   = 1'b0;
    pulse = 1'b0;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
